vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_arbiter_starve_counter.sv | 42 ++++
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter and the scan-out / host-bus blocks around it.
package vram_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DISP       = 2'd1,
        ST_HOST_ISSUE = 2'd2,
        ST_HOST_WAIT  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter_starve_counter.sv
// Saturating count of cycles the host waits un-granted; flags starvation at LIM.
module starve_counter
    import vram_pkg::*;
#(
    parameter int LIM = 64
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_pend,
    input  logic i_grant,
    output logic o_starve
);

    localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIM);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_starve;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_pend || i_grant) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Flag is compared against the next count so it tracks the counter without lag.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt    <= '0;
            r_starve <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_starve <= (w_cnt_nxt >= LIM_C);
        end
    end

    assign o_starve = r_starve;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out always wins, host accesses are
// squeezed into idle slots as a two-cycle issue/wait sequence.
//
//   state         | meaning
//   ST_IDLE       | no host access in flight, no display read issued this cycle
//   ST_DISP       | display read issued this cycle, no host access in flight
//   ST_HOST_ISSUE | host access on the memory port this cycle
//   ST_HOST_WAIT  | host data returning, HOST_ACK high; port free for a display read
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = 64
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_starve,
    output logic              o_mem_ce,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant;
    logic              w_disp_issue;
    logic              w_host_pend;
    logic              w_ack;

    logic              r_mem_ce;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_disp_pend;
    logic              r_disp_valid;
    logic              r_host_we;
    logic [DATA_W-1:0] r_host_rdata;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // While a host access is in flight the display still owns the port in the wait slot.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_disp_issue = 1'b0;
        case (r_state)
            ST_HOST_ISSUE: begin
                w_state_nxt  = ST_HOST_WAIT;
                w_disp_issue = i_disp_req;
            end
            ST_HOST_WAIT: begin
                w_state_nxt  = i_disp_req ? ST_DISP : ST_IDLE;
                w_disp_issue = i_disp_req;
            end
            default: begin
                if (i_disp_req) begin
                    w_state_nxt  = ST_DISP;
                    w_disp_issue = 1'b1;
                end else if (i_host_req) begin
                    w_state_nxt = ST_HOST_ISSUE;
                    w_grant     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign w_host_pend = i_host_req && (r_state != ST_HOST_ISSUE) && (r_state != ST_HOST_WAIT);
    assign w_ack       = (r_state == ST_HOST_WAIT);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_disp_pend  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_host_we    <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_disp_pend  <= w_disp_issue;
            r_disp_valid <= r_disp_pend;
            if (w_disp_issue) begin
                r_mem_ce   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= i_disp_addr;
            end else if (w_grant) begin
                r_mem_ce    <= 1'b1;
                r_mem_we    <= i_host_we;
                r_mem_addr  <= i_host_addr;
                r_mem_wdata <= i_host_wdata;
                r_host_we   <= i_host_we;
            end else begin
                r_mem_ce <= 1'b0;
                r_mem_we <= 1'b0;
            end
            if (w_ack && !r_host_we) begin
                r_host_rdata <= i_mem_rdata;
            end
        end
    end

    starve_counter #(
        .LIM (STARVE_LIM)
    ) u_starve (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_pend   (w_host_pend),
        .i_grant  (w_grant),
        .o_starve (o_host_starve)
    );

    // SRAM data arrives in the cycle after the strobe, so read data is passed straight through.
    assign o_disp_valid = r_disp_valid;
    assign o_disp_data  = r_disp_valid ? i_mem_rdata : '0;
    assign o_host_ack   = w_ack;
    assign o_host_rdata = (w_ack && !r_host_we) ? i_mem_rdata : r_host_rdata;
    assign o_mem_ce     = r_mem_ce;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous SRAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        host_starve;
    logic        mem_ce;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .i_clk         (clk),
        .i_nrst        (rst_n),
        .i_disp_req    (disp_req),
        .i_disp_addr   (disp_addr),
        .o_disp_valid  (disp_valid),
        .o_disp_data   (disp_data),
        .i_host_req    (host_req),
        .i_host_we     (host_we),
        .i_host_addr   (host_addr),
        .i_host_wdata  (host_wdata),
        .o_host_ack    (host_ack),
        .o_host_rdata  (host_rdata),
        .o_host_starve (host_starve),
        .o_mem_ce      (mem_ce),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ce"},    32'(mem_ce), 32'd0);
        check_val({tag, "_we"},    32'(mem_we), 32'd0);
        check_val({tag, "_addr"},  32'(mem_addr), 32'd0);
        check_val({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check_val({tag, "_dval"},  32'(disp_valid), 32'd0);
        check_val({tag, "_ddata"}, 32'(disp_data), 32'd0);
        check_val({tag, "_ack"},   32'(host_ack), 32'd0);
        check_val({tag, "_rdata"}, 32'(host_rdata), 32'd0);
        check_val({tag, "_starve"},32'(host_starve), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        disp_req = 1'b0;
        host_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [4:0] exp_ce;
        logic [4:0] exp_ack;

        for (int i = 0; i < 4; i++) mem[16'(i)] = 8'(8'hA0 + i);
        for (int i = 0; i < 3; i++) mem[16'(16'h20 + i)] = 8'(8'hB0 + i);
        mem[16'h0010] = 8'h3C;

        repeat (2) @(negedge clk);
        check_all_zero("rst");

        // display burst, first request on the first edge out of reset
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            disp_req  = (i < 4);
            disp_addr = 16'(i);
            @(negedge clk);
            check_val("d_ce", 32'(mem_ce), 32'(i < 4));
            check_val("d_we", 32'(mem_we), 32'd0);
            if (i < 4) check_val("d_addr", 32'(mem_addr), 32'(i));
            check_val("d_val", 32'(disp_valid), 32'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) check_val("d_data", 32'(disp_data), 32'(8'hA0 + i - 1));
        end
        idle_cycles(2);

        // host write
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'h55;
        @(negedge clk);
        check_val("w_ce", 32'(mem_ce), 32'd1);
        check_val("w_we", 32'(mem_we), 32'd1);
        check_val("w_addr", 32'(mem_addr), 32'h1234);
        check_val("w_wdata", 32'(mem_wdata), 32'h55);
        check_val("w_ack0", 32'(host_ack), 32'd0);
        @(negedge clk);
        check_val("w_ack1", 32'(host_ack), 32'd1);
        check_val("w_ce_off", 32'(mem_ce), 32'd0);
        host_req = 1'b0;
        @(negedge clk);
        check_val("w_ack2", 32'(host_ack), 32'd0);
        check_val("w_mem", 32'(mem[16'h1234]), 32'h55);
        idle_cycles(1);

        // host read collides with a 3-cycle display burst
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            disp_req  = (i < 3);
            disp_addr = 16'(16'h20 + i);
            @(negedge clk);
            if (i < 3) begin
                check_val("c_ce", 32'(mem_ce), 32'd1);
                check_val("c_addr", 32'(mem_addr), 32'(16'h20 + i));
            end
            if (i == 3) begin
                check_val("c_hce", 32'(mem_ce), 32'd1);
                check_val("c_hwe", 32'(mem_we), 32'd0);
                check_val("c_haddr", 32'(mem_addr), 32'h10);
            end
            check_val("c_ack", 32'(host_ack), 32'(i == 4));
            if (i >= 4) check_val("c_rdata", 32'(host_rdata), 32'h3C);
            if (i == 4) host_req = 1'b0;
            check_val("c_val", 32'(disp_valid), 32'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) check_val("c_data", 32'(disp_data), 32'(8'hB0 + i - 1));
        end
        idle_cycles(1);

        // display arrives while host access is in flight
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;
        @(negedge clk);
        check_val("f_ce", 32'(mem_ce), 32'd1);
        check_val("f_addr", 32'(mem_addr), 32'h1234);
        check_val("f_ack0", 32'(host_ack), 32'd0);
        disp_req = 1'b1; disp_addr = 16'h0021;
        @(negedge clk);
        check_val("f_ack1", 32'(host_ack), 32'd1);
        check_val("f_rdata", 32'(host_rdata), 32'h55);
        check_val("f_dce", 32'(mem_ce), 32'd1);
        check_val("f_dwe", 32'(mem_we), 32'd0);
        check_val("f_daddr", 32'(mem_addr), 32'h21);
        disp_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        check_val("f_ack2", 32'(host_ack), 32'd0);
        check_val("f_val", 32'(disp_valid), 32'd1);
        check_val("f_data", 32'(disp_data), 32'hB1);
        idle_cycles(2);

        // starvation under a long display burst
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 8'h77;
        for (int k = 0; k < 70; k++) begin
            disp_req  = 1'b1;
            disp_addr = 16'(k);
            @(negedge clk);
            check_val("s_starve", 32'(host_starve), 32'(k >= 63));
            check_val("s_addr", 32'(mem_addr), 32'(k));
            check_val("s_ack", 32'(host_ack), 32'd0);
        end
        disp_req = 1'b0;
        @(negedge clk);
        check_val("s_clr", 32'(host_starve), 32'd0);
        check_val("s_hce", 32'(mem_ce), 32'd1);
        check_val("s_hwe", 32'(mem_we), 32'd1);
        check_val("s_haddr", 32'(mem_addr), 32'h40);
        @(negedge clk);
        check_val("s_ack1", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        idle_cycles(2);

        // reset during HOST_ISSUE
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        @(negedge clk);
        check_val("r_issue", 32'(mem_ce), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("r_async");
        host_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("r_noack", 32'(host_ack), 32'd0);
            check_val("r_noce", 32'(mem_ce), 32'd0);
        end
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0050; host_wdata = 8'h99;
        @(negedge clk);
        check_val("r_nce", 32'(mem_ce), 32'd1);
        check_val("r_nwe", 32'(mem_we), 32'd1);
        check_val("r_naddr", 32'(mem_addr), 32'h50);
        check_val("r_nwdata", 32'(mem_wdata), 32'h99);
        @(negedge clk);
        check_val("r_nack", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        @(negedge clk);
        check_val("r_nmem", 32'(mem[16'h0050]), 32'h99);
        idle_cycles(1);

        // host request held across ACK: two separate accesses
        exp_ce  = 5'b01001;
        exp_ack = 5'b10010;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0060; host_wdata = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("h_ce", 32'(mem_ce), 32'(exp_ce[i]));
            check_val("h_ack", 32'(host_ack), 32'(exp_ack[i]));
        end
        host_req = 1'b0;
        @(negedge clk);
        check_val("h_ack_end", 32'(host_ack), 32'd0);
        check_val("h_mem", 32'(mem[16'h0060]), 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
